// File: rtl/tlb_maint_sequencer_pkg.sv
// rtl/tlb_maint_sequencer_pkg.sv - shared TLB maintenance codes, state encoding and field layouts
package tlb_maint_sequencer_pkg;

   // TLB instruction subtypes presented by writeback
   localparam logic [4:0] SUB_SRCH = 5'd1;
   localparam logic [4:0] SUB_RD   = 5'd2;
   localparam logic [4:0] SUB_WR   = 5'd3;
   localparam logic [4:0] SUB_FILL = 5'd4;
   localparam logic [4:0] SUB_INV  = 5'd5;

   // Highest INVTLB op the MMU understands
   localparam logic [4:0] INVTLB_OP_MAX = 5'd6;

   // MMU request types
   localparam logic [3:0] TYPE_NONE     = 4'd0;
   localparam logic [3:0] TYPE_PRIV_MMU = 4'd10;

   // Instruction-not-exist exception code
   localparam logic [5:0] ECODE_INE = 6'hD;

   // CSR write-enable patterns, bit order {ASID,ELO1,ELO0,EHI,IDX}
   localparam logic [4:0] WE_NONE = 5'b00000;
   localparam logic [4:0] WE_IDX  = 5'b00001;
   localparam logic [4:0] WE_ALL  = 5'b11111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_CAPT  = 2'd2
   } state_t;

   typedef struct packed {
      logic       valid;
      logic [8:0] subcode;
      logic [5:0] ecode;
   } excp_arg_t;

   // Unknown subtypes and out-of-range INVTLB ops raise INE instead of reaching the MMU
   function automatic logic tlb_inst_legal(input logic [4:0] subtype, input logic [4:0] op);
      logic legal;
      legal = (subtype >= SUB_SRCH) && (subtype <= SUB_INV);
      if ((subtype == SUB_INV) && (op > INVTLB_OP_MAX)) begin
         legal = 1'b0;
      end
      return legal;
   endfunction

   // Which CSRs take the MMU results when the instruction completes
   function automatic logic [4:0] capt_we(input logic [4:0] subtype);
      logic [4:0] we;
      case (subtype)
         SUB_SRCH: we = WE_IDX;
         SUB_RD:   we = WE_ALL;
         default:  we = WE_NONE;
      endcase
      return we;
   endfunction

endpackage

// File: rtl/tlb_maint_sequencer_if.sv
// rtl/tlb_maint_sequencer_if.sv - writeback-stage handshake for TLB maintenance instructions
interface tlb_maint_sequencer_if;
   logic        pipeline_TLBS_valid;
   logic [4:0]  pipeline_TLBS_subtype;
   logic [4:0]  pipeline_TLBS_op;
   logic [31:0] pipeline_TLBS_rj;
   logic [31:0] pipeline_TLBS_rk;
   logic        pipeline_TLBS_flush;
   logic        TLBS_pipeline_ready;
   logic        TLBS_pipeline_stall;
   logic        TLBS_pipeline_done;
   logic [15:0] TLBS_pipeline_excp_arg;

   // Writeback stage side
   modport master (
      output pipeline_TLBS_valid, pipeline_TLBS_subtype, pipeline_TLBS_op,
             pipeline_TLBS_rj, pipeline_TLBS_rk, pipeline_TLBS_flush,
      input  TLBS_pipeline_ready, TLBS_pipeline_stall, TLBS_pipeline_done,
             TLBS_pipeline_excp_arg
   );

   // Sequencer side
   modport slave (
      input  pipeline_TLBS_valid, pipeline_TLBS_subtype, pipeline_TLBS_op,
             pipeline_TLBS_rj, pipeline_TLBS_rk, pipeline_TLBS_flush,
      output TLBS_pipeline_ready, TLBS_pipeline_stall, TLBS_pipeline_done,
             TLBS_pipeline_excp_arg
   );
endinterface

// File: rtl/tlb_maint_sequencer_fill_index_gen.sv
// rtl/tlb_maint_sequencer_fill_index_gen.sv - free-running pseudo-random TLBFILL index
module tlbs_fill_index_gen
   import tlb_maint_sequencer_pkg::*;
#(
   parameter int TLB_n = 5
) (
   input  logic             clk,
   input  logic             rst,
   output logic [TLB_n-1:0] fill_idx_o
);

   logic [TLB_n-1:0] cnt_q;

   // Count every cycle and wrap naturally at 2^TLB_n
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + TLB_n'(1);
      end
   end

   assign fill_idx_o = cnt_q;

endmodule

// File: rtl/tlb_maint_sequencer.sv
// rtl/tlb_maint_sequencer.sv - issues one TLB maintenance op to the MMU and writes results back to CSRs
module tlb_maint_sequencer
#(
   parameter int TLB_n = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   tlb_maint_sequencer_if.slave  pipe,
   input  logic [31:0]           csr_TLBS_TLBIDX,
   input  logic [31:0]           csr_TLBS_TLBEHI,
   input  logic [31:0]           csr_TLBS_TLBELO0,
   input  logic [31:0]           csr_TLBS_TLBELO1,
   input  logic [9:0]            csr_TLBS_ASID,
   output logic [3:0]            TLBS_MMU_type,
   output logic [4:0]            TLBS_MMU_subtype,
   output logic [15:0]           TLBS_MMU_excp_arg,
   output logic [31:0]           TLBS_MMU_rj,
   output logic [31:0]           TLBS_MMU_rk,
   output logic [31:0]           TLBS_MMU_TLBIDX,
   output logic [31:0]           TLBS_MMU_TLBEHI,
   output logic [31:0]           TLBS_MMU_TLBELO0,
   output logic [31:0]           TLBS_MMU_TLBELO1,
   output logic [9:0]            TLBS_MMU_ASID,
   output logic                  TLBS_MMU_stallw,
   output logic                  TLBS_MMU_flushw,
   input  logic [31:0]           MMU_TLBS_TLBIDX,
   input  logic [31:0]           MMU_TLBS_TLBEHI,
   input  logic [31:0]           MMU_TLBS_TLBELO0,
   input  logic [31:0]           MMU_TLBS_TLBELO1,
   input  logic [9:0]            MMU_TLBS_ASID,
   output logic [4:0]            TLBS_csr_we,
   output logic [31:0]           TLBS_csr_TLBIDX,
   output logic [31:0]           TLBS_csr_TLBEHI,
   output logic [31:0]           TLBS_csr_TLBELO0,
   output logic [31:0]           TLBS_csr_TLBELO1,
   output logic [9:0]            TLBS_csr_ASID
);
   import tlb_maint_sequencer_pkg::*;

   state_t           state_q;
   logic [4:0]       subtype_q;
   logic [4:0]       op_q;
   logic [31:0]      rj_q, rk_q;
   logic [31:0]      idx_q, ehi_q, elo0_q, elo1_q;
   logic [9:0]       asid_q;
   logic [4:0]       we_q;
   logic             stallw_q;
   logic             ine_done_q;
   excp_arg_t        excp_q;

   logic [TLB_n-1:0] fill_idx;
   logic [31:0]      idx_d;
   logic             accept, in_issue, in_capt, capt_live, flush;

   tlbs_fill_index_gen #(.TLB_n(TLB_n)) u_fill_index_gen (
      .clk        (clk),
      .rst        (rst),
      .fill_idx_o (fill_idx)
   );

   assign flush     = pipe.pipeline_TLBS_flush;
   assign in_issue  = (state_q == ST_ISSUE);
   assign in_capt   = (state_q == ST_CAPT);
   assign accept    = pipe.pipeline_TLBS_valid & (state_q == ST_IDLE) & ~flush;
   // A flush during capture throws the MMU results away
   assign capt_live = in_capt & ~flush;

   assign pipe.TLBS_pipeline_ready    = accept;
   assign pipe.TLBS_pipeline_stall    = accept | in_issue | in_capt;
   assign pipe.TLBS_pipeline_done     = capt_live | ine_done_q;
   assign pipe.TLBS_pipeline_excp_arg = excp_q;

   // Flush in the issue cycle suppresses the request so the MMU never commits it
   assign TLBS_MMU_type     = (in_issue & ~flush) ? TYPE_PRIV_MMU : TYPE_NONE;
   assign TLBS_MMU_flushw   = in_issue & flush;
   assign TLBS_MMU_stallw   = stallw_q;
   assign TLBS_MMU_subtype  = subtype_q;
   assign TLBS_MMU_excp_arg = {11'b0, op_q};
   assign TLBS_MMU_rj       = rj_q;
   assign TLBS_MMU_rk       = rk_q;
   assign TLBS_MMU_TLBIDX   = idx_q;
   assign TLBS_MMU_TLBEHI   = ehi_q;
   assign TLBS_MMU_TLBELO0  = elo0_q;
   assign TLBS_MMU_TLBELO1  = elo1_q;
   assign TLBS_MMU_ASID     = asid_q;

   // MMU results are already registered on its side, so they are forwarded only in the capture cycle
   assign TLBS_csr_we      = capt_live ? we_q : WE_NONE;
   assign TLBS_csr_TLBIDX  = capt_live ? MMU_TLBS_TLBIDX  : '0;
   assign TLBS_csr_TLBEHI  = capt_live ? MMU_TLBS_TLBEHI  : '0;
   assign TLBS_csr_TLBELO0 = capt_live ? MMU_TLBS_TLBELO0 : '0;
   assign TLBS_csr_TLBELO1 = capt_live ? MMU_TLBS_TLBELO1 : '0;
   assign TLBS_csr_ASID    = capt_live ? MMU_TLBS_ASID    : '0;

   // TLBFILL ignores the software index and takes the hardware-chosen slot
   always_comb begin
      idx_d = csr_TLBS_TLBIDX;
      if (pipe.pipeline_TLBS_subtype == SUB_FILL) begin
         idx_d[TLB_n-1:0] = fill_idx;
      end
   end

   // Sequencer FSM with operand/CSR snapshot taken on accept
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         subtype_q  <= '0;
         op_q       <= '0;
         rj_q       <= '0;
         rk_q       <= '0;
         idx_q      <= '0;
         ehi_q      <= '0;
         elo0_q     <= '0;
         elo1_q     <= '0;
         asid_q     <= '0;
         we_q       <= WE_NONE;
         stallw_q   <= 1'b1;
         ine_done_q <= 1'b0;
         excp_q     <= '0;
      end else begin
         ine_done_q <= 1'b0;
         excp_q     <= '0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  subtype_q <= pipe.pipeline_TLBS_subtype;
                  op_q      <= pipe.pipeline_TLBS_op;
                  rj_q      <= pipe.pipeline_TLBS_rj;
                  rk_q      <= pipe.pipeline_TLBS_rk;
                  idx_q     <= idx_d;
                  ehi_q     <= csr_TLBS_TLBEHI;
                  elo0_q    <= csr_TLBS_TLBELO0;
                  elo1_q    <= csr_TLBS_TLBELO1;
                  asid_q    <= csr_TLBS_ASID;
                  we_q      <= capt_we(pipe.pipeline_TLBS_subtype);
                  if (tlb_inst_legal(pipe.pipeline_TLBS_subtype, pipe.pipeline_TLBS_op)) begin
                     state_q  <= ST_ISSUE;
                     stallw_q <= 1'b0;
                  end else begin
                     ine_done_q     <= 1'b1;
                     excp_q.valid   <= 1'b1;
                     excp_q.subcode <= '0;
                     excp_q.ecode   <= ECODE_INE;
                  end
               end
            end
            ST_ISSUE: begin
               if (flush) begin
                  state_q  <= ST_IDLE;
                  stallw_q <= 1'b1;
               end else begin
                  state_q  <= ST_CAPT;
               end
            end
            ST_CAPT: begin
               state_q  <= ST_IDLE;
               stallw_q <= 1'b1;
            end
            default: begin
               state_q  <= ST_IDLE;
               stallw_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
